// File: rtl/multi_dataflow_kernel_adapter_pkg.sv
// Shared types for the multi_dataflow kernel adapter: engine control/flag records,
// counter width and the adapter job-sequencing states.
package multi_dataflow_kernel_adapter_pkg;

    localparam int CNT_LEN    = 1024;
    localparam int CNT_W      = $clog2(CNT_LEN) + 1;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic             clear;
        logic             enable;
        logic             start;
        logic [CNT_W-1:0] cnt_limit_chiped_text;
    } ctrl_engine_t;

    typedef struct packed {
        logic [CNT_W-1:0] cnt_chiped_text;
        logic             done;
        logic             ready;
    } flags_engine_t;

    typedef enum logic [1:0] {
        KA_IDLE,
        KA_RUN,
        KA_DRAIN,
        KA_DONE
    } kernel_adapter_state_t;

    // Beats already counted plus beats still buffered; one extra bit so a full
    // 1024-beat job never wraps.
    function automatic logic [CNT_W:0] beats_committed(
        input logic [CNT_W-1:0] counted,
        input logic [1:0]       buffered
    );
        return {1'b0, counted} + {{(CNT_W-1){1'b0}}, buffered};
    endfunction

endpackage

// File: rtl/multi_dataflow_kernel_adapter_fifo.sv
// Two-entry register FIFO for kernel results, with a synchronous flush that
// behaves exactly like reset.
module multi_dataflow_kernel_adapter_fifo
    import multi_dataflow_kernel_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Head entry is held in a register, so output data is stable until popped.
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (push_ok && (wr_ptr_q == 1'(gi))) begin
                    mem_q[gi] <= data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multi_dataflow_kernel_adapter.sv
// Joins text/key/rc into single kernel beats, buffers kernel results and forwards
// them to the sink, sequencing one job of cnt_limit_chiped_text beats at a time.
module multi_dataflow_kernel_adapter
    import multi_dataflow_kernel_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  ctrl_engine_t            ctrl_i,
    output flags_engine_t           flags_o,
    input  logic                    text_valid_i,
    input  logic [DATA_WIDTH-1:0]   text_data_i,
    output logic                    text_ready_o,
    input  logic                    key_valid_i,
    input  logic [DATA_WIDTH-1:0]   key_data_i,
    output logic                    key_ready_o,
    input  logic                    rc_valid_i,
    input  logic [DATA_WIDTH-1:0]   rc_data_i,
    output logic                    rc_ready_o,
    output logic                    kernel_in_valid_o,
    output logic [DATA_WIDTH-1:0]   kernel_text_o,
    output logic [DATA_WIDTH-1:0]   kernel_key_o,
    output logic [DATA_WIDTH-1:0]   kernel_rc_o,
    input  logic                    kernel_in_ready_i,
    input  logic                    kernel_out_valid_i,
    input  logic [DATA_WIDTH-1:0]   kernel_out_data_i,
    output logic                    kernel_out_ready_o,
    output logic                    chiped_text_valid_o,
    output logic [DATA_WIDTH-1:0]   chiped_text_data_o,
    output logic [DATA_WIDTH/8-1:0] chiped_text_strb_o,
    input  logic                    chiped_text_ready_i
);

    localparam int STRB_W = DATA_WIDTH / 8;

    kernel_adapter_state_t state_q, state_d;
    logic [CNT_W-1:0]      limit_q, limit_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  zero_done_q, zero_done_d;

    logic                  flush;
    logic                  in_run;
    logic                  in_busy;
    logic                  join_valid;
    logic                  join_fire;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic                  room_for_result;

    assign flush   = rst_i | ctrl_i.clear;
    assign in_run  = (state_q == KA_RUN);
    assign in_busy = (state_q == KA_RUN) || (state_q == KA_DRAIN);

    // Join: all three streams must be valid, and are consumed together.
    assign join_valid = in_run & text_valid_i & key_valid_i & rc_valid_i
                      & ctrl_i.enable & (issued_q < limit_q);
    assign join_fire  = join_valid & kernel_in_ready_i;

    assign kernel_in_valid_o = join_valid;
    assign kernel_text_o     = text_data_i;
    assign kernel_key_o      = key_data_i;
    assign kernel_rc_o       = rc_data_i;
    assign text_ready_o      = join_fire;
    assign key_ready_o       = join_fire;
    assign rc_ready_o        = join_fire;

    // Never accept a result that would push the job past its beat limit.
    assign room_for_result    = beats_committed(out_cnt_q, fifo_count) < {1'b0, limit_q};
    assign kernel_out_ready_o = in_busy & ctrl_i.enable & ~fifo_full & room_for_result;
    assign fifo_push          = kernel_out_valid_i & kernel_out_ready_o;
    assign fifo_pop           = chiped_text_valid_o & chiped_text_ready_i;

    multi_dataflow_kernel_adapter_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (ctrl_i.clear),
        .push_i  (fifo_push),
        .data_i  (kernel_out_data_i),
        .pop_i   (fifo_pop),
        .data_o  (chiped_text_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign chiped_text_valid_o = ~fifo_empty;
    assign chiped_text_strb_o  = chiped_text_valid_o ? {STRB_W{1'b1}} : {STRB_W{1'b0}};

    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        issued_d    = issued_q + CNT_W'(join_fire);
        out_cnt_d   = out_cnt_q + CNT_W'(fifo_pop);
        zero_done_d = 1'b0;

        case (state_q)
            KA_IDLE: begin
                if (ctrl_i.start && ctrl_i.enable) begin
                    issued_d  = '0;
                    out_cnt_d = '0;
                    if (ctrl_i.cnt_limit_chiped_text == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        limit_d = ctrl_i.cnt_limit_chiped_text;
                        state_d = KA_RUN;
                    end
                end
            end
            KA_RUN: begin
                // Finishing is decided on the next count so done follows the last beat directly.
                if (out_cnt_d == limit_q) begin
                    state_d = KA_DONE;
                end else if (issued_d == limit_q) begin
                    state_d = KA_DRAIN;
                end
            end
            KA_DRAIN: begin
                if (out_cnt_d == limit_q) begin
                    state_d = KA_DONE;
                end
            end
            KA_DONE: begin
                state_d = KA_IDLE;
            end
            default: begin
                state_d = KA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q     <= KA_IDLE;
            limit_q     <= '0;
            issued_q    <= '0;
            out_cnt_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            issued_q    <= issued_d;
            out_cnt_q   <= out_cnt_d;
            zero_done_q <= zero_done_d;
        end
    end

    assign flags_o.cnt_chiped_text = out_cnt_q;
    assign flags_o.done            = (state_q == KA_DONE) | zero_done_q;
    assign flags_o.ready           = (state_q == KA_IDLE);

endmodule

// File: tb/tb_multi_dataflow_kernel_adapter.sv
// Self-checking bench: a job-level model (queues and counters) is compared with the
// adapter every cycle, and directed scenarios pin key cycles with literal values.
module tb_multi_dataflow_kernel_adapter;
    import multi_dataflow_kernel_adapter_pkg::*;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    ctrl_engine_t    ctrl;
    flags_engine_t   flags;
    logic            text_valid_i, key_valid_i, rc_valid_i;
    logic [DW-1:0]   text_data_i, key_data_i, rc_data_i;
    logic            text_ready_o, key_ready_o, rc_ready_o;
    logic            kernel_in_valid_o, kernel_in_ready_i;
    logic [DW-1:0]   kernel_text_o, kernel_key_o, kernel_rc_o;
    logic            kernel_out_valid_i, kernel_out_ready_o;
    logic [DW-1:0]   kernel_out_data_i;
    logic            chiped_text_valid_o, chiped_text_ready_i;
    logic [DW-1:0]   chiped_text_data_o;
    logic [DW/8-1:0] chiped_text_strb_o;

    // Environment knobs driven by the scenario process
    logic text_en = 1'b1, key_en = 1'b1, rc_en = 1'b1;
    logic kin_rdy = 1'b1, sink_rdy = 1'b1;
    logic chk_en = 1'b0;

    // Job-level model
    logic          m_run = 1'b0, m_done = 1'b0, m_done_job = 1'b0;
    int            m_limit = 0, m_issued = 0, m_cnt = 0, m_occ = 0;
    logic [7:0]    m_job = 8'd0;
    logic [15:0]   tidx = 16'd0, kidx = 16'd0, ridx = 16'd0;
    logic [DW-1:0] kq[$];
    logic          kout_valid = 1'b0;
    logic [DW-1:0] kout_data = '0;

    // Per-cycle snapshot taken away from the clock edge
    logic          s_rst = 1'b1, s_clear = 1'b0, s_start = 1'b0, s_en = 1'b0;
    int            s_limit = 0;
    logic          s_t = 1'b0, s_k = 1'b0, s_r = 1'b0, s_push = 1'b0, s_pop = 1'b0;
    logic [DW-1:0] s_kin_text = '0;

    int n_in_fire = 0, n_push = 0;
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    assign text_valid_i       = text_en;
    assign key_valid_i        = key_en;
    assign rc_valid_i         = rc_en;
    assign text_data_i        = {8'h10, m_job, tidx};
    assign key_data_i         = {8'h20, m_job, kidx};
    assign rc_data_i          = {8'h30, m_job, ridx};
    assign kernel_in_ready_i  = kin_rdy;
    assign kernel_out_valid_i = kout_valid;
    assign kernel_out_data_i  = kout_data;
    assign chiped_text_ready_i = sink_rdy;

    multi_dataflow_kernel_adapter #(.DATA_WIDTH(DW)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .ctrl_i              (ctrl),
        .flags_o             (flags),
        .text_valid_i        (text_valid_i),
        .text_data_i         (text_data_i),
        .text_ready_o        (text_ready_o),
        .key_valid_i         (key_valid_i),
        .key_data_i          (key_data_i),
        .key_ready_o         (key_ready_o),
        .rc_valid_i          (rc_valid_i),
        .rc_data_i           (rc_data_i),
        .rc_ready_o          (rc_ready_o),
        .kernel_in_valid_o   (kernel_in_valid_o),
        .kernel_text_o       (kernel_text_o),
        .kernel_key_o        (kernel_key_o),
        .kernel_rc_o         (kernel_rc_o),
        .kernel_in_ready_i   (kernel_in_ready_i),
        .kernel_out_valid_i  (kernel_out_valid_i),
        .kernel_out_data_i   (kernel_out_data_i),
        .kernel_out_ready_o  (kernel_out_ready_o),
        .chiped_text_valid_o (chiped_text_valid_o),
        .chiped_text_data_o  (chiped_text_data_o),
        .chiped_text_strb_o  (chiped_text_strb_o),
        .chiped_text_ready_i (chiped_text_ready_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Snapshot and every-cycle comparison against the model
    always @(negedge clk) begin
        logic e_kv, e_kr;
        s_rst      = rst;
        s_clear    = ctrl.clear;
        s_start    = ctrl.start;
        s_en       = ctrl.enable;
        s_limit    = int'(ctrl.cnt_limit_chiped_text);
        s_t        = text_ready_o;
        s_k        = key_ready_o;
        s_r        = rc_ready_o;
        s_push     = kernel_out_valid_i & kernel_out_ready_o;
        s_pop      = chiped_text_valid_o & chiped_text_ready_i;
        s_kin_text = kernel_text_o;
        if (text_ready_o) n_in_fire++;
        if (s_push) n_push++;
        if (chk_en && !rst) begin
            e_kv = m_run && text_en && key_en && rc_en && ctrl.enable && (m_issued < m_limit);
            e_kr = m_run && ctrl.enable && (m_occ < 2) && (m_cnt + m_occ < m_limit);
            chk("kin_valid", 32'(kernel_in_valid_o), 32'(e_kv));
            chk("text_ready", 32'(text_ready_o), 32'(e_kv && kin_rdy));
            chk("key_ready", 32'(key_ready_o), 32'(e_kv && kin_rdy));
            chk("rc_ready", 32'(rc_ready_o), 32'(e_kv && kin_rdy));
            if (e_kv) begin
                chk("join_text", kernel_text_o, {8'h10, m_job, 16'(m_issued)});
                chk("join_key", kernel_key_o, {8'h20, m_job, 16'(m_issued)});
                chk("join_rc", kernel_rc_o, {8'h30, m_job, 16'(m_issued)});
            end
            chk("kout_ready", 32'(kernel_out_ready_o), 32'(e_kr));
            chk("out_valid", 32'(chiped_text_valid_o), 32'(m_occ > 0));
            chk("out_strb", 32'(chiped_text_strb_o), (m_occ > 0) ? 32'hF : 32'h0);
            if (m_occ > 0) chk("out_data", chiped_text_data_o, {8'h10, m_job, 16'(m_cnt)});
            chk("cnt", 32'(flags.cnt_chiped_text), 32'(m_cnt));
            chk("done", 32'(flags.done), 32'(m_done));
            chk("ready", 32'(flags.ready), 32'(!m_run && !m_done_job));
        end
    end

    // Model advance, including the kernel stub that echoes text one cycle later
    always @(posedge clk) begin
        logic idle;
        #1;
        if (s_rst || s_clear) begin
            m_run = 1'b0; m_done = 1'b0; m_done_job = 1'b0;
            m_issued = 0; m_cnt = 0; m_occ = 0;
            tidx = '0; kidx = '0; ridx = '0;
            kq.delete();
        end else begin
            idle = !m_run && !m_done_job;
            m_done = 1'b0;
            m_done_job = 1'b0;
            if (s_t) tidx++;
            if (s_k) kidx++;
            if (s_r) ridx++;
            if (s_push) begin
                void'(kq.pop_front());
                m_occ++;
            end
            if (s_t) begin
                m_issued++;
                kq.push_back(s_kin_text);
            end
            if (s_pop) begin
                m_occ--;
                m_cnt++;
            end
            if (m_run && m_cnt == m_limit) begin
                m_run = 1'b0; m_done = 1'b1; m_done_job = 1'b1;
            end
            if (idle && s_start && s_en) begin
                m_cnt = 0; m_issued = 0;
                tidx = '0; kidx = '0; ridx = '0;
                if (s_limit == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_run = 1'b1;
                    m_limit = s_limit;
                    m_job++;
                end
            end
        end
        kout_valid = (kq.size() > 0);
        kout_data  = kout_valid ? kq[0] : '0;
    end

    task automatic start_job(input int lim);
        @(posedge clk); #1;
        ctrl.start = 1'b1;
        ctrl.cnt_limit_chiped_text = CNT_W'(lim);
        @(posedge clk); #1;
        ctrl.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (flags.done) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) chk("done_timeout", 32'(flags.done), 32'h1);
    endtask

    initial begin
        int c, n0, p0;
        ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ctrl.enable = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(flags.ready), 32'h1);
        chk("rst_cnt", 32'(flags.cnt_chiped_text), 32'h0);
        chk("rst_done", 32'(flags.done), 32'h0);
        chk("rst_out_valid", 32'(chiped_text_valid_o), 32'h0);
        chk("rst_kout_ready", 32'(kernel_out_ready_o), 32'h0);

        // Job 1: limit 4, free-flowing
        start_job(4);
        wait_done(50, c);
        chk("t1_done_cycle", 32'(c), 32'd7);
        chk("t1_cnt", 32'(flags.cnt_chiped_text), 32'd4);
        chk("t1_ready_in_done", 32'(flags.ready), 32'h0);
        @(negedge clk);
        chk("t1_ready_after", 32'(flags.ready), 32'h1);
        chk("t1_done_after", 32'(flags.done), 32'h0);
        chk("t1_cnt_held", 32'(flags.cnt_chiped_text), 32'd4);

        // Job 2: key stream stalls for 3 cycles mid-job
        start_job(4);
        @(posedge clk); #1;
        key_en = 1'b0;
        n0 = n_in_fire;
        repeat (3) @(posedge clk);
        #1;
        key_en = 1'b1;
        chk("t2_gap_fires", 32'(n_in_fire - n0), 32'd0);
        wait_done(50, c);
        chk("t2_cnt", 32'(flags.cnt_chiped_text), 32'd4);

        // Job 3: sink stalled for 10 cycles, limit 8
        sink_rdy = 1'b0;
        start_job(8);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("t3_kout_ready_full", 32'(kernel_out_ready_o), 32'h0);
        chk("t3_out_valid", 32'(chiped_text_valid_o), 32'h1);
        chk("t3_out_head", chiped_text_data_o, 32'h1003_0000);
        @(posedge clk); #1;
        sink_rdy = 1'b1;
        wait_done(100, c);
        chk("t3_cnt", 32'(flags.cnt_chiped_text), 32'd8);

        // Zero-length job
        n0 = n_in_fire;
        start_job(0);
        wait_done(10, c);
        chk("t4_done_cycle", 32'(c), 32'd1);
        chk("t4_ready", 32'(flags.ready), 32'h1);
        @(negedge clk);
        chk("t4_done_pulse", 32'(flags.done), 32'h0);
        chk("t4_fires", 32'(n_in_fire - n0), 32'd0);

        // Job 4 cleared at cnt 3, then job 5 with limit 2
        start_job(8);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (flags.cnt_chiped_text == CNT_W'(3)) break;
        end
        chk("t5_reached_3", 32'(flags.cnt_chiped_text), 32'd3);
        ctrl.clear = 1'b1;
        @(posedge clk); #1;
        ctrl.clear = 1'b0;
        @(negedge clk);
        chk("t5_clr_cnt", 32'(flags.cnt_chiped_text), 32'd0);
        chk("t5_clr_out_valid", 32'(chiped_text_valid_o), 32'h0);
        chk("t5_clr_kin_valid", 32'(kernel_in_valid_o), 32'h0);
        chk("t5_clr_ready", 32'(flags.ready), 32'h1);
        start_job(2);
        wait_done(50, c);
        chk("t5_cnt", 32'(flags.cnt_chiped_text), 32'd2);

        // Job 6: limit 1024 with a 5-cycle enable drop
        start_job(1024);
        repeat (20) @(posedge clk);
        #1;
        ctrl.enable = 1'b0;
        n0 = n_in_fire;
        p0 = n_push;
        repeat (5) @(posedge clk);
        #1;
        ctrl.enable = 1'b1;
        chk("t6_off_fires", 32'(n_in_fire - n0), 32'd0);
        chk("t6_off_pushes", 32'(n_push - p0), 32'd0);
        wait_done(3000, c);
        chk("t6_cnt", 32'(flags.cnt_chiped_text), 32'd1024);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_dataflow_kernel_adapter.md
Name: multi_dataflow_kernel_adapter

Overview:
Engine-side stage between the multi_dataflow streamer and the multi_dataflow kernel. It joins the three input streams (text, key, rc) into one kernel input beat per transfer. It buffers the kernel's chiped_text results in a 2-entry FIFO and forwards them to the streamer sink. It counts output beats against cnt_limit_chiped_text and reports done/ready/count through flags_engine_t.

Parameters:
DATA_WIDTH, 32, width of every data stream and of the kernel data ports
CNT_LEN, 1024, maximum beats per job; CNT_W = $clog2(CNT_LEN)+1 = 11
FIFO_DEPTH, 2, output buffer depth, fixed at 2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
ctrl_i  in  ctrl_engine_t  fields: clear, enable, start, cnt_limit_chiped_text[CNT_W-1:0]
flags_o  out  flags_engine_t  fields: cnt_chiped_text[CNT_W-1:0], done, ready
text_valid_i / text_data_i / text_ready_o  in/in/out  1/DATA_WIDTH/1  text input stream
key_valid_i / key_data_i / key_ready_o  in/in/out  1/DATA_WIDTH/1  key input stream
rc_valid_i / rc_data_i / rc_ready_o  in/in/out  1/DATA_WIDTH/1  rc input stream
kernel_in_valid_o  out  1  joined beat valid to kernel
kernel_text_o, kernel_key_o, kernel_rc_o  out  DATA_WIDTH each  joined beat data
kernel_in_ready_i  in  1  kernel accepts beat
kernel_out_valid_i / kernel_out_data_i / kernel_out_ready_o  in/in/out  1/DATA_WIDTH/1  kernel result stream
chiped_text_valid_o / chiped_text_data_o / chiped_text_strb_o / chiped_text_ready_i  out/out/out/in  1/DATA_WIDTH/DATA_WIDTH/8/1  output stream to sink

Behaviour:
- Reset (rst_i=1) and ctrl_i.clear=1 act identically and take effect from any state. rst_i wins if both are asserted.
- Reset values: state IDLE; all ready/valid outputs 0; FIFO empty; issued counter 0; cnt_chiped_text 0; done 0; flags_o.ready 1.
- States:
  - IDLE: flags_o.ready=1.
    - start=1 and enable=1 with limit≠0 → RUN next cycle. The limit is latched, issued and out counters are cleared.
    - start=1 with limit=0 → done pulses for 1 cycle; state stays IDLE.
    - start=1 while enable=0 is ignored.
  - RUN: join is active; flags_o.ready=0.
  - DRAIN: entered when issued==limit. Input readies are held 0; waits for outstanding results.
  - DONE: entered when out count==limit. done=1 for exactly one cycle, then IDLE. The count is held until the next start.
- Join (RUN only):
  - kernel_in_valid_o = text_valid & key_valid & rc_valid & enable & (issued<limit).
  - text/key/rc_ready_o are all equal to kernel_in_valid_o & kernel_in_ready_i. The three inputs are consumed in the same cycle, never individually.
  - kernel data outputs pass through combinationally. issued increments on each fire.
- Output FIFO:
  - kernel_out_ready_o = !full & enable, in RUN or DRAIN.
  - Push on kernel_out_valid_i & kernel_out_ready_o. Pop on chiped_text_valid_o & chiped_text_ready_i.
  - Simultaneous push and pop while not full keeps occupancy. No bypass: push-to-output latency is 1 cycle.
- Output stream:
  - chiped_text_valid_o = !empty.
  - strb is all ones while valid, 0 otherwise.
  - Once valid is asserted, data stays stable until the handshake, regardless of enable.
- Counting:
  - cnt_chiped_text increments by 1 per output handshake, width CNT_W; a count of 1024 fits.
  - A kernel result arriving while out count + occupancy == limit is not accepted (ready held 0).
- enable=0 in RUN/DRAIN freezes new handshakes (join and FIFO push). State and counters hold.
- clear mid-job: the FIFO is flushed and pending data is discarded. Upstream beats already consumed are lost; software re-programs the job.

Decomposition:
- multi_dataflow_package gains:
  - localparam CNT_W;
  - typedef enum kernel_adapter_state_t {KA_IDLE, KA_RUN, KA_DRAIN, KA_DONE}.
- ctrl_engine_t / flags_engine_t are reused unchanged.
- One sub-module: multi_dataflow_kernel_adapter_fifo, a 2-entry register FIFO with synchronous clear, full and empty outputs.

Test Plan:
- Reset, then start with limit=4, all streams always valid/ready, kernel echoes text after 1 cycle → 4 joins, 4 output beats, cnt=4, done high for 1 cycle in the 6th-8th cycle window, then ready=1.
- key_valid_i low for 3 cycles mid-job, text and rc valid → no input ready asserts during the gap, with no partial consumption; the job completes with 4 beats in order.
- chiped_text_ready_i=0 for 10 cycles, limit=8 → FIFO fills to 2 and kernel_out_ready_o drops. Output data stays stable; after release all 8 beats arrive with none lost or duplicated.
- start with limit=0 → done pulse the next cycle, no stream readies asserted, state stays IDLE.
- clear asserted when cnt=3 of limit 8 → the next cycle shows cnt=0, FIFO empty, all valids 0, ready=1; a new start with limit=2 completes normally.
- enable=0 for 5 cycles in RUN with inputs valid → zero handshakes and counters frozen; on re-enable the job completes with limit=1024 and the final cnt reads 1024.
